// File: rtl/bcd_conv_pkg.sv
// Shared constants and FSM encoding for the BCD-to-binary converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_CORR   = 4'd3;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  localparam int unsigned DEF_DIGITS = 3;
  localparam int unsigned DEF_BIN_W  = 10;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD nibble correction step of reverse double-dabble: subtract 3 when >= 8.
module bcd_digit_adjust
  import bcd_conv_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted_c
);

  always_comb begin
    adjusted_c = digit;
    if (digit >= ADJ_THRESH) adjusted_c = digit - ADJ_CORR;
  end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter using reverse double-dabble,
// one shift/adjust per clock for BIN_W clocks.
module bcd_to_binary_converter
  import bcd_conv_pkg::*;
#(
  parameter int unsigned DIGITS = DEF_DIGITS,
  parameter int unsigned BIN_W  = DEF_BIN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_input,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary_output,
  output logic                  invalid
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BIN_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   bcd_sh_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BIN_W-1:0]   acc_sh_c;
  logic               in_valid_c;

  function automatic logic digits_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

  assign in_valid_c = digits_valid(bcd_input);

  // The BCD field's lsb falls into the accumulator msb on every shift.
  assign {bcd_sh_c, acc_sh_c} = {bcd_reg, acc} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit      (bcd_sh_c[4*g +: 4]),
      .adjusted_c (bcd_adj_c[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bcd_reg       <= '0;
      acc           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      invalid       <= 1'b0;
      binary_output <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_input;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            if (in_valid_c) begin
              state <= SHIFT;
            end else begin
              state         <= DONE;
              invalid       <= 1'b1;
              binary_output <= '0;
              done          <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj_c;
          acc     <= acc_sh_c;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            binary_output <= acc_sh_c;
            invalid       <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed self-checking bench for bcd_to_binary_converter (default parameters).
module tb_bcd_to_binary_converter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_input;
  logic        busy;
  logic        done;
  logic [9:0]  binary_output;
  logic        invalid;

  int total = 0;
  int bad   = 0;

  bcd_to_binary_converter dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .bcd_input     (bcd_input),
    .busy          (busy),
    .done          (done),
    .binary_output (binary_output),
    .invalid       (invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one request at the next edge (E0) and watches 20 cycles.
  // inj_at: cycle at which a second start with 0x456 is pulsed.
  // rst_at: edge just after which rst is asserted asynchronously.
  task automatic run(input string tag, input logic [11:0] v, input int exp_bin,
                     input logic exp_inv, input int exp_pulses, input int exp_done_at,
                     input int exp_busy, input int inj_at, input int rst_at);
    int busy_cnt, done_cnt, done_at;
    logic [9:0] prev_out;
    logic stable;
    busy_cnt = 0; done_cnt = 0; done_at = -1; stable = 1'b1;
    prev_out  = binary_output;
    start     = 1'b1;
    bcd_input = v;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = k; end
      if (busy && !done && (rst_at == 0 || k <= rst_at) && binary_output !== prev_out)
        stable = 1'b0;
      if (k == inj_at) begin
        start = 1'b1; bcd_input = 12'h456;
      end else begin
        start = 1'b0; bcd_input = 12'hFFF;
      end
      if (k == rst_at + 1 && rst_at > 0) rst = 1'b0;
      if (k == rst_at && rst_at > 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check({tag, " rst busy"}, 32'(busy), 32'd0);
        check({tag, " rst done"}, 32'(done), 32'd0);
        check({tag, " rst invalid"}, 32'(invalid), 32'd0);
        check({tag, " rst binary"}, 32'(binary_output), 32'd0);
      end
    end
    check({tag, " done pulses"}, 32'(done_cnt), 32'(exp_pulses));
    if (exp_pulses > 0) check({tag, " done cycle"}, 32'(done_at), 32'(exp_done_at));
    if (exp_busy >= 0) check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, " binary"}, 32'(binary_output), 32'(exp_bin));
    check({tag, " invalid"}, 32'(invalid), 32'(exp_inv));
    check({tag, " output held while busy"}, 32'(stable), 32'd1);
  endtask

  initial begin
    int b2b_dones, b2b_second;
    rst = 1'b1; start = 1'b0; bcd_input = 12'h000;
    #3;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset invalid", 32'(invalid), 32'd0);
    check("reset binary", 32'(binary_output), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run("zero", 12'h000, 0, 1'b0, 1, 11, 11, 0, 0);
    run("max", 12'h999, 999, 1'b0, 1, 11, 11, 0, 0);
    for (int nn = 0; nn < 32; nn++) begin
      logic [11:0] v;
      v = {4'h0, 4'(nn / 10), 4'(nn % 10)};
      run($sformatf("nn%0d", nn), v, nn, 1'b0, 1, 11, 11, 0, 0);
    end
    run("bad digit", 12'h1A5, 0, 1'b1, 1, 1, 1, 0, 0);
    run("after bad", 12'h042, 42, 1'b0, 1, 11, 11, 0, 0);
    run("ignore start", 12'h123, 123, 1'b0, 1, 11, 11, 5, 0);
    run("abort", 12'h777, 0, 1'b0, 0, 0, -1, 0, 4);
    run("after abort", 12'h777, 777, 1'b0, 1, 11, 11, 0, 0);
    run("mid digits", 12'h580, 580, 1'b0, 1, 11, 11, 0, 0);

    // start held high: conversions accepted at E0 and E12
    b2b_dones = 0; b2b_second = -1;
    start = 1'b1; bcd_input = 12'h050;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        b2b_dones++;
        if (b2b_dones == 2) b2b_second = k;
      end
    end
    start = 1'b0;
    check("back-to-back dones", 32'(b2b_dones), 32'd2);
    check("back-to-back second done cycle", 32'(b2b_second), 32'd23);
    check("back-to-back binary", 32'(binary_output), 32'd50);
    for (int k = 0; k < 15; k++) @(negedge clk);
    check("back-to-back idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_converter.md
BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 The block SHALL have a parameter DIGITS, default 3: number of packed BCD digits on bcd_input.
REQ-002 The block SHALL have a parameter BIN_W, default 10: binary result width, with the constraint 2**BIN_W >= 10**DIGITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port bcd_input, input, 4*DIGITS bits: packed BCD, most significant digit in the top nibble.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port binary_output, output, BIN_W bits: converted value.
REQ-010 The block SHALL have port invalid, output, 1 bit: the last request held a digit greater than 9.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at a rising edge (E0), the block SHALL capture bcd_input into an internal register and clear the iteration counter and the binary accumulator.
REQ-013 Also at E0, if every captured nibble is 0..9, the block SHALL go to SHIFT; otherwise it SHALL go to DONE with invalid=1 and binary_output=0.
REQ-014 On each SHIFT cycle the block SHALL shift the concatenation {bcd register, binary accumulator} right by one bit, then subtract 3 from every BCD nibble whose value is 8 or more (reverse double-dabble).
REQ-015 SHIFT SHALL last exactly BIN_W edges (E1..E_BIN_W); at edge E_BIN_W the block SHALL load binary_output from the accumulator, clear invalid, and go to DONE.
REQ-016 done SHALL be high only while in DONE, for exactly one cycle; DONE SHALL always go to IDLE on the next edge.
REQ-017 With defaults, done SHALL be high in the cycle after E10 for a valid input, and in the cycle after E0 for an invalid input.
REQ-018 start SHALL be ignored while busy=1; no request is queued.
REQ-019 start held high continuously SHALL cause back-to-back conversions, with the next one accepted at the first edge in IDLE.
REQ-020 binary_output and invalid SHALL hold their values from DONE until the next conversion completes; they SHALL NOT change during SHIFT.
REQ-021 The arithmetic SHALL use no multipliers; the result SHALL be exact for every valid input 0..10**DIGITS-1, with no overflow given the REQ-002 constraint.
REQ-022 bcd_input SHALL be sampled only at E0; later changes SHALL NOT affect the conversion in progress.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, busy=0, done=0, invalid=0 and binary_output=0, and clear the counter and internal registers, irrespective of clk.
REQ-024 Reset asserted during SHIFT or DONE SHALL abort the conversion; no done pulse SHALL follow.
REQ-025 The first start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-026 A shared package bcd_conv_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, DONE), the per-digit constants (adjust threshold 8, correction 3, maximum digit 9), and the default DIGITS/BIN_W values.
REQ-027 One combinational sub-module, bcd_digit_adjust, SHALL perform the 4-bit "if value >= 8 then subtract 3" step; DIGITS instances SHALL be generated inside the top.
REQ-028 The digit-validity check SHALL be a combinational function of the captured nibbles, in the top level.

Verification
REQ-029 Scenario: start with bcd_input=0x000 -> done in the cycle after E10, binary_output=0, invalid=0, busy high for exactly 11 cycles.
REQ-030 Scenario: start with bcd_input=0x999 -> binary_output=999 (0x3E7), invalid=0.
REQ-031 Scenario: start with bcd_input=0x0NN for every NN in 00..31 (BCD) -> binary_output=NN decimal, i.e. round-trip with the team's 5-bit binary-to-BCD converter.
REQ-032 Scenario: start with bcd_input=0x1A5 -> done in the cycle after E0, invalid=1, binary_output=0; then start with 0x042 -> binary_output=42, invalid=0.
REQ-033 Scenario: start with 0x123, then pulse start with 0x456 at E5 -> the second request is ignored, binary_output=123, and only one done pulse occurs.
REQ-034 Scenario: start with 0x777, then assert rst at E4 -> all outputs are 0 at once and no done pulse occurs; after release, start with 0x777 -> binary_output=777.
